// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings and small helpers for the iterative multiply/divide sequencer.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_WB   = 2'b11
  } state_e;

  // Quotient reported for any divide by zero.
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  function automatic logic is_div_op(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
// hi/lo hold {accumulator, multiplier} for a product, {remainder, dividend/quotient} for a divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Compute both candidate updates and pick the one matching the operation.
  // NOTE: every output gets a value on every path of this always_comb, so no latch is inferred.
  always_comb begin
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
    shifted = {hi_i, lo_i[WIDTH-1]};
    diff    = shifted - {1'b0, b_i};
    if (is_div_i) begin
      if (!diff[WIDTH]) begin
        hi_o = diff[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
        hi_o = shifted[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Add-or-skip, then shift the 65-bit {carry, hi, lo} right by one.
      hi_o = sum[WIDTH:1];
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: latch operands, 32 iterations, sign fix-up, one-cycle Lo/Hi write.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   rs,
  input  logic [WIDTH-1:0]   rt,
  input  logic               flush,
  input  logic               rd_req,
  output logic               busy,
  output logic               stall,
  output logic               wen,
  output logic               is_mult,
  output logic [2*WIDTH-1:0] p
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  op_e                  op_q, op_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 neg_q_q, neg_q_d;   // product / quotient negative
  logic                 neg_r_q, neg_r_d;   // remainder negative
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 is_mult_q, is_mult_d;

  logic [WIDTH-1:0]     step_hi, step_lo;
  op_e                  in_op;
  logic                 in_sa, in_sb;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     q_fix, r_fix;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div_op(op_q)),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .b_i      (b_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  // Operand magnitudes and signs for the op arriving from EX.
  assign in_op = op_e'(op);
  assign in_sa = is_signed_op(in_op) & rs[WIDTH-1];
  assign in_sb = is_signed_op(in_op) & rt[WIDTH-1];
  assign a_abs = in_sa ? -rs : rs;
  assign b_abs = in_sb ? -rt : rt;

  // Sign fix-up candidates applied in FIX.
  assign prod_fix = neg_q_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign q_fix    = neg_q_q ? -lo_q : lo_q;
  assign r_fix    = neg_r_q ? -hi_q : hi_q;

  // Status and write-port outputs; the result is forwarded straight from hi/lo during WB.
  assign busy    = (state_q != S_IDLE);
  assign stall   = busy & (start | rd_req);
  assign wen     = (state_q == S_WB) & ~flush;
  assign p       = wen ? {hi_q, lo_q} : p_q;
  assign is_mult = wen ? ~is_div_op(op_q) : is_mult_q;

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    p_d       = p_q;
    is_mult_d = is_mult_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d    = in_op;
          hi_d    = '0;
          neg_q_d = in_sa ^ in_sb;
          neg_r_d = in_sa;
          cnt_d   = '0;
          state_d = S_RUN;
          if (is_div_op(in_op)) begin
            b_d  = b_abs;   // divisor
            lo_d = a_abs;   // dividend, shifted out as quotient shifts in
          end else begin
            b_d  = a_abs;   // multiplicand
            lo_d = b_abs;   // multiplier, consumed LSB first
          end
        end
      end
      S_RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_WB;
        if (!is_div_op(op_q)) begin
          {hi_d, lo_d} = prod_fix;
        end else if (b_q == '0) begin
          // Divide by zero leaves |rs| in the remainder; restoring its sign yields the original rs.
          hi_d = r_fix;
          lo_d = DIV0_QUOT;
        end else begin
          hi_d = r_fix;
          lo_d = q_fix;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
        if (!flush) begin
          p_d       = {hi_q, lo_q};
          is_mult_d = ~is_div_op(op_q);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // State, counter and datapath registers.
  // NOTE: datapath registers are reset along with the FSM so p and is_mult read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MULT;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      p_q       <= '0;
      is_mult_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      p_q       <= p_d;
      is_mult_q <= is_mult_d;
    end
  end

endmodule
